// File: rtl/tt_um_drops.sv
// Falling-drop animation on a seven-segment digit.
// A programmable prescaler paces a drop through the TOP..BOTTOM frames.
// Each drop ends in a SPLASH frame, which advances an 8-bit drop counter,
// and the drop then alternates between the left and right columns.
module tt_um_drops (
  input  logic       clk,
  input  logic       rst_n,    // active-high despite the name
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    TOP    = 3'd1,
    UPPER  = 3'd2,
    MID    = 3'd3,
    LOWER  = 3'd4,
    BOTTOM = 3'd5,
    SPLASH = 3'd6
  } state_t;

  state_t      state, state_next;
  logic [10:0] prescaler;
  logic [11:0] period;
  logic        col;
  logic [7:0]  drops;
  logic        step_s1, step_s2, step_prev;
  logic        pause;
  logic        tick, timer_tick, step_tick;

  // Spare inputs are intentionally ignored.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, ui_in[7:5], uio_in};

  assign pause      = ui_in[3];
  // The period needs 12 bits because speed 7 gives 2048.
  assign period     = 12'd16 << ui_in[2:0];
  // Compare with >= so that lowering the speed mid-count fires on the next cycle.
  assign timer_tick = !pause && ({1'b0, prescaler} >= (period - 12'd1));
  assign step_tick  = pause && step_s2 && !step_prev;
  assign tick       = timer_tick || step_tick;

  // Prescaler, step synchroniser, drop counter, column bit and state register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      prescaler <= '0;
      step_s1   <= 1'b0;
      step_s2   <= 1'b0;
      step_prev <= 1'b0;
      drops     <= '0;
      col       <= 1'b0;
      state     <= IDLE;
    end else if (ena) begin
      step_s1   <= ui_in[4];
      step_s2   <= step_s1;
      step_prev <= step_s2;
      if (timer_tick)
        prescaler <= '0;
      else if (!pause)
        prescaler <= prescaler + 11'd1;
      if (tick && state == BOTTOM)
        drops <= drops + 8'd1;
      if (tick && state == SPLASH)
        col <= ~col;
      state <= state_next;
    end
  end

  // Next-state logic: one frame per tick; IDLE is only re-entered via reset.
  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_next = state;
    if (tick) begin
      unique case (state)
        IDLE:    state_next = TOP;
        TOP:     state_next = UPPER;
        UPPER:   state_next = MID;
        MID:     state_next = LOWER;
        LOWER:   state_next = BOTTOM;
        BOTTOM:  state_next = SPLASH;
        SPLASH:  state_next = TOP;
        default: state_next = IDLE;
      endcase
    end
  end

  // Segment decode straight from the state register (bit0=a .. bit6=g).
  always_comb begin
    uo_out = 8'h00;
    unique case (state)
      IDLE:    uo_out = 8'h00;
      TOP:     uo_out = 8'h01;                  // a
      UPPER:   uo_out = col ? 8'h02 : 8'h20;    // b : f
      MID:     uo_out = 8'h40;                  // g
      LOWER:   uo_out = col ? 8'h04 : 8'h10;    // c : e
      BOTTOM:  uo_out = 8'h08;                  // d
      SPLASH:  uo_out = 8'h9C;                  // c+d+e plus splash flag
      default: uo_out = 8'h00;
    endcase
  end

  assign uio_out = drops;
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_drops.sv
// Directed bench for tt_um_drops with hand-computed frame timings.
module tb_tt_um_drops;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int tests_run = 0;
  int tests_failed = 0;

  tt_um_drops dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %02h expected %02h", tag, actual, expected);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic step_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold reset, set inputs, release between edges; edge 1 follows release.
  task automatic do_reset(input logic [7:0] ui);
    rst_n  = 1'b1;
    ena    = 1'b1;
    ui_in  = ui;
    uio_in = 8'hA5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  logic [7:0] seq_seg [12] = '{8'h01, 8'h20, 8'h40, 8'h10, 8'h08, 8'h9C,
                               8'h01, 8'h02, 8'h40, 8'h04, 8'h08, 8'h9C};
  logic [7:0] seq_cnt [12] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                               8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h02};

  initial begin
    rst_n  = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;

    // Speed 0: frames every 16 clocks, left column then right column.
    do_reset(8'h00);
    #1;
    check("rst_seg", uo_out, 8'h00);
    check("rst_cnt", uio_out, 8'h00);
    check("rst_oe", uio_oe, 8'hFF);
    step_clk(15);
    check("s0_pre_first", uo_out, 8'h00);
    step_clk(1);
    check("s0_frame0", uo_out, seq_seg[0]);
    check("s0_cnt0", uio_out, seq_cnt[0]);
    for (int i = 1; i < 12; i++) begin
      step_clk(15);
      check($sformatf("s0_hold%0d", i), uo_out, seq_seg[i-1]);
      step_clk(1);
      check($sformatf("s0_frame%0d", i), uo_out, seq_seg[i]);
      check($sformatf("s0_cnt%0d", i), uio_out, seq_cnt[i]);
    end

    // Asynchronous reset mid-animation, observed with no clock edge.
    #1;
    rst_n = 1'b1;
    #1;
    check("async_rst_seg", uo_out, 8'h00);
    check("async_rst_cnt", uio_out, 8'h00);
    check("async_rst_oe", uio_oe, 8'hFF);

    // Speed 3: period 128.
    do_reset(8'h03);
    step_clk(127);
    check("s3_pre_first", uo_out, 8'h00);
    step_clk(1);
    check("s3_first", uo_out, 8'h01);
    step_clk(127);
    check("s3_hold", uo_out, 8'h01);
    step_clk(1);
    check("s3_second", uo_out, 8'h20);

    // Pause and single-step.
    do_reset(8'h08);
    step_clk(5000);
    check("pause_hold", uo_out, 8'h00);
    ui_in = 8'h18;
    step_clk(2);
    check("step_sync_lat", uo_out, 8'h00);
    step_clk(1);
    check("step_adv", uo_out, 8'h01);
    step_clk(50);
    check("step_once", uo_out, 8'h01);
    ui_in = 8'h08;
    step_clk(5);
    ui_in = 8'h10;     // step edge while running must be ignored
    step_clk(5);
    check("step_unpaused", uo_out, 8'h01);
    step_clk(10);
    check("run_pre", uo_out, 8'h01);
    step_clk(1);
    check("run_adv", uo_out, 8'h20);

    // Lowering the speed mid-count fires on the next cycle.
    do_reset(8'h02);   // period 64
    step_clk(40);
    ui_in = 8'h00;     // count already 40 >= 15
    step_clk(1);
    check("speed_drop", uo_out, 8'h01);

    // Enable freeze.
    do_reset(8'h00);
    step_clk(20);      // TOP, prescaler at 4
    ena = 1'b0;
    step_clk(1000);
    check("ena_seg", uo_out, 8'h01);
    check("ena_cnt", uio_out, 8'h00);
    ena = 1'b1;
    step_clk(11);
    check("ena_resume_pre", uo_out, 8'h01);
    step_clk(1);
    check("ena_resume", uo_out, 8'h20);

    // Counter wrap after 256 drops; column returns to left.
    do_reset(8'h00);
    step_clk(96 * 255);
    check("wrap_255_seg", uo_out, 8'h9C);
    check("wrap_255_cnt", uio_out, 8'hFF);
    step_clk(96);
    check("wrap_256_seg", uo_out, 8'h9C);
    check("wrap_256_cnt", uio_out, 8'h00);
    step_clk(32);
    check("wrap_col_left", uo_out, 8'h20);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
